// File: rtl/elevator_pkg.sv
// Shared encodings for the car controller and the TIMEOUT unit.
// Both blocks import this package so they agree on what each estado means.
package elevator_pkg;

    localparam int ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        IDLE = 3'd0,
        OPEN = 3'd1,
        UP   = 3'd2,
        DOWN = 3'd3,
        STOP = 3'd4
    } estado_t;

    // Plain constants for FSM code that works on raw estado vectors.
    localparam logic [ESTADO_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ESTADO_W-1:0] ST_OPEN = 3'd1;
    localparam logic [ESTADO_W-1:0] ST_UP   = 3'd2;
    localparam logic [ESTADO_W-1:0] ST_DOWN = 3'd3;
    localparam logic [ESTADO_W-1:0] ST_STOP = 3'd4;

endpackage

// File: rtl/elevator_if.sv
// Car-side bundle: call inputs and TIMEOUT pulse in, state/motor/door out.
// master = the controller, slave = whoever drives requests and timeouts.
interface elevator_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8
) ();
    localparam int FLOOR_W = $clog2(NUM_FLOORS);

    logic [NUM_FLOORS-1:0] req;
    logic                  timeout;
    logic [ESTADO_W-1:0]   estado;
    logic [FLOOR_W-1:0]    floor;
    logic                  dir_up;
    logic                  motor_up;
    logic                  motor_down;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        input  req, timeout,
        output estado, floor, dir_up, motor_up, motor_down, door_open, pending
    );

    modport slave (
        output req, timeout,
        input  estado, floor, dir_up, motor_up, motor_down, door_open, pending
    );
endinterface

// File: rtl/elevator_req_scan.sv
// Reduces the outstanding-request vector to the three SCAN terms
// relative to the current floor: a request here, anywhere above, anywhere below.
module elevator_req_scan
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]    i_floor,
    output logic                  o_here,
    output logic                  o_above,
    output logic                  o_below
);

    // Classify every floor against the car position and OR each group.
    always_comb begin
        o_here  = 1'b0;
        o_above = 1'b0;
        o_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) == i_floor)
                o_here = o_here | i_pending[i];
            else if (FLOOR_W'(i) > i_floor)
                o_above = o_above | i_pending[i];
            else
                o_below = o_below | i_pending[i];
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN (collective) elevator car controller: latches calls, moves one floor
// per TIMEOUT interval, opens the door at requested floors. Outputs are
// Moore-decoded from the registered estado.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic       clk,
    input  logic       rst_n,
    elevator_if.master bus
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    logic [ESTADO_W-1:0]   r_estado;
    logic [FLOOR_W-1:0]    r_floor;
    logic                  r_dir_up;
    logic [NUM_FLOORS-1:0] r_pending;

    logic [ESTADO_W-1:0]   w_estado_next;
    logic [FLOOR_W-1:0]    w_floor_next;
    logic                  w_dir_next;
    logic [NUM_FLOORS-1:0] w_pending_next;
    logic                  w_here;
    logic                  w_above;
    logic                  w_below;
    logic [ESTADO_W-1:0]   w_dec_estado;
    logic                  w_dec_dir;

    elevator_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .i_pending (r_pending),
        .i_floor   (r_floor),
        .o_here    (w_here),
        .o_above   (w_above),
        .o_below   (w_below)
    );

    // SCAN decision used from IDLE and STOP: serve here, keep going the
    // current way while work remains ahead, otherwise reverse.
    always_comb begin
        w_dec_estado = ST_IDLE;
        w_dec_dir    = r_dir_up;
        if (w_here) begin
            w_dec_estado = ST_OPEN;
        end else if (r_dir_up && w_above) begin
            w_dec_estado = ST_UP;
        end else if (!r_dir_up && w_below) begin
            w_dec_estado = ST_DOWN;
        end else if (w_above) begin
            w_dec_estado = ST_UP;
            w_dec_dir    = 1'b1;
        end else if (w_below) begin
            w_dec_estado = ST_DOWN;
            w_dec_dir    = 1'b0;
        end
    end

    // Next state, direction and floor; floor steps saturate at both ends
    // even though the scan terms already make overrun impossible.
    always_comb begin
        w_estado_next = r_estado;
        w_dir_next    = r_dir_up;
        w_floor_next  = r_floor;
        case (r_estado)
            ST_IDLE, ST_STOP: begin
                w_estado_next = w_dec_estado;
                w_dir_next    = w_dec_dir;
            end
            ST_OPEN: begin
                if (bus.timeout)
                    w_estado_next = ST_STOP;
            end
            ST_UP: begin
                if (bus.timeout) begin
                    w_estado_next = ST_STOP;
                    if (r_floor != TOP_FLOOR)
                        w_floor_next = r_floor + FLOOR_W'(1);
                end
            end
            ST_DOWN: begin
                if (bus.timeout) begin
                    w_estado_next = ST_STOP;
                    if (r_floor != '0)
                        w_floor_next = r_floor - FLOOR_W'(1);
                end
            end
            default: w_estado_next = ST_IDLE;
        endcase
    end

    // Request latch; the current floor is cleared on entry to OPEN and on
    // every edge spent in OPEN, with the clear winning over a new call.
    always_comb begin
        w_pending_next = r_pending | bus.req;
        if (w_estado_next == ST_OPEN || r_estado == ST_OPEN) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (FLOOR_W'(i) == r_floor)
                    w_pending_next[i] = 1'b0;
            end
        end
    end

    // Controller state registers; reset parks the car at floor 0, idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= ST_IDLE;
            r_floor   <= '0;
            r_dir_up  <= 1'b1;
            r_pending <= '0;
        end else begin
            r_estado  <= w_estado_next;
            r_floor   <= w_floor_next;
            r_dir_up  <= w_dir_next;
            r_pending <= w_pending_next;
        end
    end

    assign bus.estado     = r_estado;
    assign bus.floor      = r_floor;
    assign bus.dir_up     = r_dir_up;
    assign bus.pending    = r_pending;
    assign bus.door_open  = (r_estado == ST_OPEN);
    assign bus.motor_up   = (r_estado == ST_UP);
    assign bus.motor_down = (r_estado == ST_DOWN);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: the bench plays the call buttons and
// the TIMEOUT unit; expected values are hand-derived per scenario.
module tb_elevator_ctrl;
    import elevator_pkg::*;

    localparam int NF = 8;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    elevator_if #(.NUM_FLOORS(NF)) bus ();

    elevator_ctrl #(.NUM_FLOORS(NF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tmo();
        bus.timeout = 1'b1;
        step();
        bus.timeout = 1'b0;
    endtask

    task automatic chk_st(input string tag, input logic [2:0] est, input int flr);
        chk({tag, ".estado"}, 32'(bus.estado), 32'(est));
        chk({tag, ".floor"}, 32'(bus.floor), 32'(flr));
    endtask

    // Motor drives must never be on together, checked on every falling edge.
    always @(negedge clk) begin
        if (rst_n)
            chk("motor_excl", 32'(bus.motor_up & bus.motor_down), 32'd0);
    end

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.timeout = 1'b0;
        step();
        step();
        chk_st("rst", ST_IDLE, 0);
        chk("rst.dir_up", 32'(bus.dir_up), 32'd1);
        chk("rst.pending", 32'(bus.pending), 32'd0);
        chk("rst.outs", 32'({bus.motor_up, bus.motor_down, bus.door_open}), 32'd0);
        rst_n = 1'b1;
        step();

        // Call at the current floor: latch, then open.
        bus.req = 8'h01;
        step();
        bus.req = '0;
        chk("t1.pending", 32'(bus.pending), 32'h01);
        chk_st("t1.latch", ST_IDLE, 0);
        step();
        chk_st("t1.open", ST_OPEN, 0);
        chk("t1.door", 32'(bus.door_open), 32'd1);
        chk("t1.clr", 32'(bus.pending), 32'd0);
        tmo();
        chk_st("t1.stop", ST_STOP, 0);
        chk("t1.door_off", 32'(bus.door_open), 32'd0);
        step();
        chk_st("t1.idle", ST_IDLE, 0);
        // timeout has no effect in IDLE
        tmo();
        chk_st("t1.ign", ST_IDLE, 0);

        // Travel 0 -> 3.
        bus.req = 8'h08;
        step();
        bus.req = '0;
        step();
        chk_st("t2.up", ST_UP, 0);
        chk("t2.motor", 32'(bus.motor_up), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tmo();
            chk_st("t2.stop", ST_STOP, k);
            step();
            chk_st("t2.next", (k < 3) ? ST_UP : ST_OPEN, k);
        end
        chk("t2.clr", 32'(bus.pending), 32'd0);
        tmo();
        step();
        chk_st("t2.idle", ST_IDLE, 3);

        // Calls at 5 and 1 from floor 3 heading up: 5 first, then reverse.
        bus.req = 8'h22;
        step();
        bus.req = '0;
        step();
        chk_st("t3.up", ST_UP, 3);
        chk("t3.dir", 32'(bus.dir_up), 32'd1);
        tmo();
        step();
        chk_st("t3.up4", ST_UP, 4);
        tmo();
        step();
        chk_st("t3.open5", ST_OPEN, 5);
        chk("t3.pend", 32'(bus.pending), 32'h02);
        tmo();
        step();
        chk_st("t3.down", ST_DOWN, 5);
        chk("t3.dir_dn", 32'(bus.dir_up), 32'd0);
        chk("t3.motor_dn", 32'(bus.motor_down), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tmo();
            chk_st("t3.stop", ST_STOP, 5 - k);
            step();
            chk_st("t3.next", (k < 4) ? ST_DOWN : ST_OPEN, 5 - k);
        end
        chk("t3.clr", 32'(bus.pending), 32'd0);
        tmo();
        step();
        chk_st("t3.idle", ST_IDLE, 1);

        // Reset back to floor 0, then 0 -> 4 with a call at 2 added en route.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_st("t4.rst", ST_IDLE, 0);
        bus.req = 8'h10;
        step();
        bus.req = '0;
        step();
        chk_st("t4.up", ST_UP, 0);
        tmo();
        step();
        chk_st("t4.up1", ST_UP, 1);
        bus.req = 8'h04;
        step();
        bus.req = '0;
        chk("t4.pend", 32'(bus.pending), 32'h14);
        tmo();
        step();
        chk_st("t4.open2", ST_OPEN, 2);
        chk("t4.pend2", 32'(bus.pending), 32'h10);
        tmo();
        step();
        chk_st("t4.up2", ST_UP, 2);
        tmo();
        step();
        chk_st("t4.up3", ST_UP, 3);
        tmo();
        step();
        chk_st("t4.open4", ST_OPEN, 4);
        chk("t4.clr", 32'(bus.pending), 32'd0);
        tmo();
        step();
        chk_st("t4.idle", ST_IDLE, 4);

        // Asynchronous reset while moving down from 4 with 0 and 2 pending.
        bus.req = 8'h05;
        step();
        bus.req = '0;
        step();
        chk_st("t5.down", ST_DOWN, 4);
        chk("t5.pend", 32'(bus.pending), 32'h05);
        rst_n = 1'b0;
        #1;
        chk_st("t5.rst", ST_IDLE, 0);
        chk("t5.pend0", 32'(bus.pending), 32'd0);
        chk("t5.motors", 32'({bus.motor_up, bus.motor_down}), 32'd0);
        chk("t5.dir", 32'(bus.dir_up), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk_st("t5.stay", ST_IDLE, 0);

        // Run to the top floor, hold its call during OPEN: no reopen.
        bus.req = 8'h80;
        step();
        bus.req = '0;
        step();
        for (int k = 1; k <= 7; k++) begin
            tmo();
            chk_st("t6.stop", ST_STOP, k);
            step();
            chk_st("t6.next", (k < 7) ? ST_UP : ST_OPEN, k);
        end
        bus.req = 8'h80;
        step();
        chk("t6.hold1", 32'(bus.pending), 32'd0);
        step();
        chk("t6.hold2", 32'(bus.pending), 32'd0);
        chk_st("t6.still", ST_OPEN, 7);
        bus.req = '0;
        tmo();
        chk_st("t6.stop7", ST_STOP, 7);
        step();
        chk_st("t6.noreopen", ST_IDLE, 7);
        chk("t6.no_up", 32'(bus.motor_up), 32'd0);
        bus.req = 8'h80;
        step();
        bus.req = '0;
        step();
        chk_st("t6.top_open", ST_OPEN, 7);
        chk("t6.top_no_up", 32'(bus.motor_up), 32'd0);
        tmo();
        step();
        chk_st("t6.idle", ST_IDLE, 7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
